// File: rtl/rtp_rx_depack.sv
// rtp_rx_depack: receive-side RTP depacketizer. Validates the 12-byte header of each
// UDP payload and queues the big-endian 16-bit PCM samples for DAC playback.
module rtp_rx_depack #(
  parameter logic [31:0] SSRC   = 32'h12345678,
  parameter logic [6:0]  PT     = 7'd0,
  parameter int          ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              udp_rec_data_valid,
  input  logic [7:0]        udp_rec_rdata,
  input  logic [15:0]       udp_rec_data_length,
  input  logic              wav_rden,
  output logic [15:0]       wav_out_data,
  output logic              wav_out_valid,
  output logic [ADDR_W:0]   fifo_level,
  output logic [15:0]       pkt_ok_cnt,
  output logic [15:0]       pkt_drop_cnt,
  output logic              seq_gap,
  output logic              fifo_overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LVL_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Expected SSRC byte for header bytes 8..11 (index low bits select the byte).
  function automatic logic [7:0] ssrc_byte(input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = SSRC[31:24];
      2'd1:    b = SSRC[23:16];
      2'd2:    b = SSRC[15:8];
      default: b = SSRC[7:0];
    endcase
    return b;
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [15:0]       len_q, len_d;
  logic              hdr_ok_q, hdr_ok_d;
  logic [15:0]       seq_q, seq_d;
  logic [15:0]       last_seq_q, last_seq_d;
  logic              seq_valid_q, seq_valid_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic              wr_req_q, wr_req_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [15:0]       pkt_ok_cnt_q, pkt_ok_cnt_d;
  logic [15:0]       pkt_drop_cnt_q, pkt_drop_cnt_d;
  logic              seq_gap_q, seq_gap_d;

  logic [15:0]       mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              rd_pend_q, rd_pend_d;
  logic [15:0]       rd_dat_q, rd_dat_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_data_q, out_data_d;

  logic [15:0]       byte_nxt_s;
  logic              last_byte_s;
  logic              hdr_pass_s;
  logic              do_wr_s;
  logic              do_rd_s;

  // Packet parser: header checks, sample pairing and packet accounting.
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    len_d          = len_q;
    hdr_ok_d       = hdr_ok_q;
    seq_d          = seq_q;
    last_seq_d     = last_seq_q;
    seq_valid_d    = seq_valid_q;
    hi_byte_d      = hi_byte_q;
    wr_req_d       = 1'b0;
    wr_data_d      = wr_data_q;
    pkt_ok_cnt_d   = pkt_ok_cnt_q;
    pkt_drop_cnt_d = pkt_drop_cnt_q;
    seq_gap_d      = 1'b0;
    byte_nxt_s     = byte_cnt_q + 16'd1;
    last_byte_s    = (byte_nxt_s == len_q);
    hdr_pass_s     = hdr_ok_q && (udp_rec_rdata == ssrc_byte(byte_cnt_q[1:0]));

    if (udp_rec_data_valid) begin
      case (state_q)
        IDLE: begin
          len_d      = udp_rec_data_length;
          byte_cnt_d = 16'd1;
          hdr_ok_d   = (udp_rec_rdata == 8'h80);
          if (udp_rec_data_length <= 16'd1) begin
            // Whole packet is this one byte.
            byte_cnt_d     = 16'd0;
            pkt_drop_cnt_d = pkt_drop_cnt_q + 16'd1;
          end else if ((udp_rec_data_length < 16'd14) || udp_rec_data_length[0]) begin
            state_d        = DISCARD;
            pkt_drop_cnt_d = pkt_drop_cnt_q + 16'd1;
          end else begin
            state_d = HEADER;
          end
        end
        HEADER: begin
          byte_cnt_d = byte_nxt_s;
          case (byte_cnt_q)
            16'd1:                 hdr_ok_d = hdr_ok_q && (udp_rec_rdata[6:0] == PT);
            16'd2:                 seq_d[15:8] = udp_rec_rdata;
            16'd3:                 seq_d[7:0]  = udp_rec_rdata;
            16'd8, 16'd9, 16'd10:  hdr_ok_d = hdr_pass_s;
            16'd11: begin
              if (hdr_pass_s) begin
                state_d      = PAYLOAD;
                pkt_ok_cnt_d = pkt_ok_cnt_q + 16'd1;
                seq_gap_d    = seq_valid_q && (seq_q != last_seq_q + 16'd1);
                last_seq_d   = seq_q;
                seq_valid_d  = 1'b1;
              end else begin
                state_d        = last_byte_s ? IDLE : DISCARD;
                pkt_drop_cnt_d = pkt_drop_cnt_q + 16'd1;
              end
            end
            default: hdr_ok_d = hdr_ok_q;
          endcase
        end
        PAYLOAD: begin
          byte_cnt_d = byte_nxt_s;
          if (byte_cnt_q[0]) begin
            wr_req_d  = 1'b1;
            wr_data_d = {hi_byte_q, udp_rec_rdata};
          end else begin
            hi_byte_d = udp_rec_rdata;
          end
          if (last_byte_s) begin
            state_d = IDLE;
          end else begin
            state_d = PAYLOAD;
          end
        end
        DISCARD: begin
          byte_cnt_d = byte_nxt_s;
          if (last_byte_s) begin
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sample FIFO: a write into a full FIFO is dropped even when a read shares the cycle.
  always_comb begin
    do_wr_s     = wr_req_q && (level_q != DEPTH);
    do_rd_s     = wav_rden && (level_q != {(ADDR_W+1){1'b0}});
    wr_ptr_d    = do_wr_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = do_rd_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d  = overflow_q || (wr_req_q && (level_q == DEPTH));
    rd_pend_d   = do_rd_s;
    rd_dat_d    = do_rd_s ? mem_q[rd_ptr_q] : rd_dat_q;
    out_valid_d = rd_pend_q;
    out_data_d  = rd_pend_q ? rd_dat_q : out_data_q;
    case ({do_wr_s, do_rd_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      byte_cnt_q     <= 16'd0;
      len_q          <= 16'd0;
      hdr_ok_q       <= 1'b0;
      seq_q          <= 16'd0;
      last_seq_q     <= 16'd0;
      seq_valid_q    <= 1'b0;
      hi_byte_q      <= 8'd0;
      wr_req_q       <= 1'b0;
      wr_data_q      <= 16'd0;
      pkt_ok_cnt_q   <= 16'd0;
      pkt_drop_cnt_q <= 16'd0;
      seq_gap_q      <= 1'b0;
      wr_ptr_q       <= {ADDR_W{1'b0}};
      rd_ptr_q       <= {ADDR_W{1'b0}};
      level_q        <= {(ADDR_W+1){1'b0}};
      overflow_q     <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_dat_q       <= 16'd0;
      out_valid_q    <= 1'b0;
      out_data_q     <= 16'd0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      len_q          <= len_d;
      hdr_ok_q       <= hdr_ok_d;
      seq_q          <= seq_d;
      last_seq_q     <= last_seq_d;
      seq_valid_q    <= seq_valid_d;
      hi_byte_q      <= hi_byte_d;
      wr_req_q       <= wr_req_d;
      wr_data_q      <= wr_data_d;
      pkt_ok_cnt_q   <= pkt_ok_cnt_d;
      pkt_drop_cnt_q <= pkt_drop_cnt_d;
      seq_gap_q      <= seq_gap_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      overflow_q     <= overflow_d;
      rd_pend_q      <= rd_pend_d;
      rd_dat_q       <= rd_dat_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
    end
  end

  assign wav_out_data  = out_data_q;
  assign wav_out_valid = out_valid_q;
  assign fifo_level    = level_q;
  assign pkt_ok_cnt    = pkt_ok_cnt_q;
  assign pkt_drop_cnt  = pkt_drop_cnt_q;
  assign seq_gap       = seq_gap_q;
  assign fifo_overflow = overflow_q;

endmodule
